// File: rtl/div_pipe_if.sv
// Shared request/result types and the IX/WB handshake bundle of the DIV execution pipe.
// slave = divider side, master = issue stage / writeback side.
package div_pipe_pkg;
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        div_op_e     div_control;
    } ix_div_inf_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
    } div_wb_inf_t;
endpackage

interface div_pipe_if;
    import div_pipe_pkg::*;

    logic        ix_div_valid;
    logic        ix_div_ready;
    ix_div_inf_t ix_div;
    logic        div_wb_valid;
    logic        wb_div_ready;
    div_wb_inf_t div_wb;

    modport slave (
        input  ix_div_valid, ix_div, wb_div_ready,
        output ix_div_ready, div_wb_valid, div_wb
    );

    modport master (
        output ix_div_valid, ix_div, wb_div_ready,
        input  ix_div_ready, div_wb_valid, div_wb
    );
endinterface

// File: rtl/div_pipe.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, RADIX_BITS quotient bits per cycle.
// Result is held in DONE until writeback grants it; divide-by-zero skips the iteration.
module div_pipe
    import div_pipe_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic      clk,
    input  logic      arst_n,
    div_pipe_if.slave bus
);
    localparam int         ITERS = 32 / RADIX_BITS;
    localparam logic [5:0] LAST  = 6'(ITERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    function automatic logic [31:0] f_neg(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? f_neg(v) : v;
    endfunction

    state_e      r_state;
    logic [5:0]  r_cnt;
    div_wb_inf_t r_wb;

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic [4:0]  r_rd;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_accept;
    logic        w_signed;
    logic        w_is_rem;
    logic [31:0] w_rem;
    logic [31:0] w_quo;
    logic [32:0] w_sh;
    logic [32:0] w_trial;
    logic [31:0] w_result;

    assign bus.ix_div_ready = (r_state == S_IDLE);
    assign bus.div_wb_valid = (r_state == S_DONE);
    assign bus.div_wb       = r_wb;

    assign w_accept = bus.ix_div_valid && (r_state == S_IDLE);
    assign w_signed = (bus.ix_div.div_control == DIV_OP_DIV) ||
                      (bus.ix_div.div_control == DIV_OP_REM);
    assign w_is_rem = (bus.ix_div.div_control == DIV_OP_REM) ||
                      (bus.ix_div.div_control == DIV_OP_REMU);

    // The shifted remainder is kept at 33 bits: with a divisor near 2^32 it can exceed 32 bits before the subtract.
    always_comb begin
        w_rem   = r_rem;
        w_quo   = r_quo;
        w_sh    = '0;
        w_trial = '0;
        for (int i = 0; i < RADIX_BITS; i++) begin
            w_sh    = {w_rem, w_quo[31]};
            w_trial = w_sh - {1'b0, r_divisor};
            w_rem   = w_trial[32] ? w_sh[31:0] : w_trial[31:0];
            w_quo   = {w_quo[30:0], ~w_trial[32]};
        end
    end

    assign w_result = r_is_rem ? (r_neg_r ? f_neg(w_rem) : w_rem)
                               : (r_neg_q ? f_neg(w_quo) : w_quo);

    // Control and output register; the datapath below needs no reset since every accept reloads it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wb    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        if (bus.ix_div.rs2 == 32'd0) begin
                            r_state   <= S_DONE;
                            r_wb.rd   <= bus.ix_div.rd;
                            r_wb.result <= w_is_rem ? bus.ix_div.rs1 : 32'hFFFF_FFFF;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == LAST) begin
                        r_state     <= S_DONE;
                        r_wb.rd     <= r_rd;
                        r_wb.result <= w_result;
                    end
                end
                S_DONE: begin
                    if (bus.wb_div_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rem     <= '0;
            r_quo     <= f_mag(bus.ix_div.rs1, w_signed);
            r_divisor <= f_mag(bus.ix_div.rs2, w_signed);
            r_rd      <= bus.ix_div.rd;
            r_is_rem  <= w_is_rem;
            r_neg_q   <= w_signed && (bus.ix_div.rs1[31] ^ bus.ix_div.rs2[31]);
            r_neg_r   <= w_signed && bus.ix_div.rs1[31];
        end else if (r_state == S_CALC) begin
            r_rem <= w_rem;
            r_quo <= w_quo;
        end
    end
endmodule
